// File: rtl/gshare_predictor.sv
// Dual-slot gshare branch predictor: XOR-indexed pattern history table of
// saturating counters, speculative global history, misprediction recovery.
module gshare_predictor #(
  parameter int ADDR_W   = 8,
  parameter int IDX_W    = 5,
  parameter int HIST_W   = 5,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] InstrAddr_F1,
  input  logic [ADDR_W-1:0] InstrAddr_F2,
  input  logic              is_branch1,
  input  logic              is_branch2,
  output logic              prediction1,
  output logic              prediction2,
  output logic [HIST_W-1:0] ghr_F1,
  output logic [HIST_W-1:0] ghr_F2,
  input  logic              update_signal1,
  input  logic              update_signal2,
  input  logic [ADDR_W-1:0] InstrAddr_E1,
  input  logic [ADDR_W-1:0] InstrAddr_E2,
  input  logic [HIST_W-1:0] ghr_E1,
  input  logic [HIST_W-1:0] ghr_E2,
  input  logic              actual_outcome1,
  input  logic              actual_outcome2,
  input  logic              mispredict1,
  input  logic              mispredict2
);

  localparam int              ENTRIES  = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_MIN  = '0;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a,
                                             input logic [HIST_W-1:0] h);
    return a[IDX_W-1:0] ^ IDX_W'(h);
  endfunction

  // Shift written without a [HIST_W-2:0] slice so HIST_W=1 elaborates.
  function automatic logic [HIST_W-1:0] f_shift(input logic [HIST_W-1:0] h,
                                                input logic b);
    logic [HIST_W-1:0] r;
    r    = h << 1;
    r[0] = b;
    return r;
  endfunction

  function automatic logic [CTR_W-1:0] f_sat(input logic [CTR_W-1:0] c,
                                             input logic taken);
    logic [CTR_W-1:0] r;
    r = c;
    if (taken) begin
      if (c != CTR_MAX) r = c + 1'b1;
    end else begin
      if (c != CTR_MIN) r = c - 1'b1;
    end
    return r;
  endfunction

  logic [CTR_W-1:0]  r_pht [ENTRIES];
  logic [HIST_W-1:0] r_ghr;

  logic [IDX_W-1:0]  w_idx_f1, w_idx_f2, w_idx_e1, w_idx_e2;
  logic [HIST_W-1:0] w_ghr_f2, w_ghr_fetch, w_ghr_nxt;
  logic              w_pred1, w_pred2_raw, w_pred2;
  logic              w_wr1, w_wr2, w_rec1, w_rec2;
  logic [CTR_W-1:0]  w_ctr_e1, w_base_e2, w_ctr_e2;

  // Fetch side: slot 2 sees history already extended by slot 1's guess.
  always_comb begin
    w_idx_f1    = f_idx(InstrAddr_F1, r_ghr);
    w_pred1     = r_pht[w_idx_f1][CTR_W-1] & is_branch1;
    w_ghr_f2    = is_branch1 ? f_shift(r_ghr, w_pred1) : r_ghr;
    w_idx_f2    = f_idx(InstrAddr_F2, w_ghr_f2);
    w_pred2_raw = r_pht[w_idx_f2][CTR_W-1] & is_branch2;
    w_pred2     = w_pred2_raw & ~w_pred1;
    w_ghr_fetch = (is_branch2 && !w_pred1) ? f_shift(w_ghr_f2, w_pred2) : w_ghr_f2;
  end

  assign prediction1 = w_pred1;
  assign prediction2 = w_pred2;
  assign ghr_F1      = r_ghr;
  assign ghr_F2      = w_ghr_f2;

  // Execute side: slot 2 is wrong-path whenever slot 1 mispredicted.
  always_comb begin
    w_wr1     = update_signal1;
    w_rec1    = update_signal1 & mispredict1;
    w_wr2     = update_signal2 & ~w_rec1;
    w_rec2    = w_wr2 & mispredict2;
    w_idx_e1  = f_idx(InstrAddr_E1, ghr_E1);
    w_idx_e2  = f_idx(InstrAddr_E2, ghr_E2);
    w_ctr_e1  = f_sat(r_pht[w_idx_e1], actual_outcome1);
    w_base_e2 = (w_wr1 && (w_idx_e1 == w_idx_e2)) ? w_ctr_e1 : r_pht[w_idx_e2];
    w_ctr_e2  = f_sat(w_base_e2, actual_outcome2);
  end

  always_comb begin
    w_ghr_nxt = r_ghr;
    if (w_rec1)           w_ghr_nxt = f_shift(ghr_E1, actual_outcome1);
    else if (w_rec2)      w_ghr_nxt = f_shift(ghr_E2, actual_outcome2);
    else if (fetch_valid) w_ghr_nxt = w_ghr_fetch;
  end

  // On a shared index slot 2's write lands last and already includes slot 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) r_pht[i] <= CTR_INIT;
      r_ghr <= '0;
    end else begin
      if (w_wr1) r_pht[w_idx_e1] <= w_ctr_e1;
      if (w_wr2) r_pht[w_idx_e2] <= w_ctr_e2;
      r_ghr <= w_ghr_nxt;
    end
  end

  generate
    if (ADDR_W > IDX_W) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^{InstrAddr_F1[ADDR_W-1:IDX_W], InstrAddr_F2[ADDR_W-1:IDX_W],
                                  InstrAddr_E1[ADDR_W-1:IDX_W], InstrAddr_E2[ADDR_W-1:IDX_W]};
    end
  endgenerate

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Dual-slot gshare branch predictor with a parametrised pattern history table, an internal speculative global history register, and misprediction recovery. It sits between fetch (two instruction slots per cycle) and the execute-stage resolution logic. It predicts both fetch slots combinationally and accepts two same-cycle counter updates, applied in program order. It replaces the fixed 32-entry, single-update predictor.

## Interface
Parameters:
- `ADDR_W`, 8: instruction address width.
- `IDX_W`, 5: table index width; the table has 2^IDX_W entries.
- `HIST_W`, 5: global history length; legal range 1..IDX_W.
- `CTR_W`, 2: saturating counter width; legal range 2..4.
- `INIT_CTR`, 1: counter reset value (weakly not-taken for CTR_W=2).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `fetch_valid`  in  1  fetch bundle accepted this cycle; advances the speculative history.
- `InstrAddr_F1`, `InstrAddr_F2`  in  ADDR_W  slot 1 (older) and slot 2 fetch addresses.
- `is_branch1`, `is_branch2`  in  1  slot holds a conditional branch.
- `prediction1`, `prediction2`  out  1  predicted taken.
- `ghr_F1`, `ghr_F2`  out  HIST_W  history used to index each slot; travels down the pipe.
- `update_signal1`, `update_signal2`  in  1  resolved branch in execute slot 1 (older) / slot 2.
- `InstrAddr_E1`, `InstrAddr_E2`  in  ADDR_W  resolved branch addresses.
- `ghr_E1`, `ghr_E2`  in  HIST_W  history captured at fetch for the resolved branches.
- `actual_outcome1`, `actual_outcome2`  in  1  resolved direction.
- `mispredict1`, `mispredict2`  in  1  resolved direction differed from the prediction. Valid only with the matching update signal.

## Operation
- Index: idx(a, h) = a[IDX_W-1:0] XOR zero-extended h.
- Prediction: counter MSB at idx, AND-ed with the slot's is_branch.
- `ghr_F1` equals the current GHR.
- `ghr_F2` equals {GHR[HIST_W-2:0], prediction1} when is_branch1=1; otherwise it equals GHR.
- Slot 2 is indexed with `ghr_F2`.
- `prediction2` is forced to 0 when `prediction1`=1, because slot 2 is on the wrong path.
- Counter update for each active update channel: saturating +1 when the outcome is taken, -1 when not taken. Counters clamp at 0 and at 2^CTR_W-1.
- Both updates in one cycle:
  - Different indices: both are written.
  - Same index: the counter takes the sequential result, slot 1 then slot 2. Example: 3 + taken + not-taken gives 2, not 3.
- `mispredict1` suppresses `update_signal2` in the same cycle, because that branch is wrong-path.
- Next GHR, in priority order:
  1. `mispredict1` sets GHR to {ghr_E1[HIST_W-2:0], actual_outcome1}.
  2. Otherwise `mispredict2` sets GHR to {ghr_E2[HIST_W-2:0], actual_outcome2}.
  3. Otherwise, when fetch_valid=1, one bit is shifted in for each branch slot, oldest first. Slot 2 is skipped when prediction1=1. The result is {ghr_F2 shifted by prediction2} when is_branch2 is set and not squashed; otherwise it is ghr_F2.
  4. Otherwise GHR holds.
- A recovery cycle discards that cycle's fetch shift; fetch redirects the next cycle.
- A fetch address equal to an update index in the same cycle reads the pre-update counter. There is no bypass.

## Timing
- Predictions and `ghr_F*` are combinational from the current table, the GHR and the fetch inputs.
- Table writes and GHR changes take effect at the rising clock edge; they are visible one cycle after the update cycle.
- Reset (rst=0, asynchronous):
  - All counters are set to INIT_CTR and GHR to 0.
  - All ports on the update and recovery path are ignored.
  - Outputs during and after reset: prediction = INIT_CTR MSB & is_branch (0 with defaults); ghr_F1 = 0.
- Reset deassertion must be synchronous to clk; the first update is accepted on the first edge with rst=1.
- Reset asserted mid-update aborts the update; no partial counter write survives.

## Test plan
- Reset, then is_branch1=1, addr 0x03 → prediction1=0, ghr_F1=0. Apply two taken updates to idx 3 with ghr_E=0 → counter 3, prediction1=1.
- Counter at 3, four more taken updates → stays 3. Drive it to 0 with not-taken updates, then one more not-taken → stays 0.
- Same-cycle dual update on the same idx from counter 1:
  - taken+taken → 3.
  - taken+not-taken → 1.
  - Different indices → both change.
- GHR=0b00001, both slots branch, pred1=0, pred2=1, fetch_valid=1 → next GHR=0b00101. When pred1=1 instead: prediction2=0 and next GHR=0b00011.
- mispredict1 with ghr_E1=0b10110, actual=1, plus a simultaneous mispredict2 and fetch_valid → GHR=0b01101 next cycle; update2 has no table effect.
- Assert rst mid-stream with counters trained → all predictions return to 0 and GHR=0 immediately, without waiting for a clock edge.
